example5_preimage: RTL and testbench

Sequential inverse of the example5 logic (g = (x1&x3)|(x2&x4), h = (x1|x3)&(x2|x4), f = g|h). Given a requested output pattern on f/g/h, with don't-care masking, it scans all 16 input vectors and streams out each x1..x4 combination that produces that pattern over a valid/ready port, then reports the match count. It is the decoder side of example5. Verification benches use it to generate the stimulus sets for a chosen output condition.

---
 rtl/example5_preimage.sv | 136 +++++++++++++
 tb/tb_example5_preimage.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/example5_preimage.sv
// example5_preimage: sequential inverse of the example5 logic.
// Scans all 16 (x4,x3,x2,x1) vectors and streams, in ascending order, every
// vector whose f/g/h outputs match the requested pattern (with don't-care
// masking). A one-cycle done pulse then reports the match count.
module example5_preimage (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       want_f,
  input  logic       want_g,
  input  logic       want_h,
  input  logic       care_f,
  input  logic       care_g,
  input  logic       care_h,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [3:0] m_x,
  output logic       busy,
  output logic       done,
  output logic [4:0] count,
  output logic       none
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t     state_q;
  logic [3:0] idx_q;
  logic [2:0] want_q;   // {f, g, h}
  logic [2:0] care_q;   // {f, g, h}
  logic       m_valid_q;
  logic [3:0] m_x_q;
  logic       busy_q;
  logic       done_q;
  logic [4:0] count_q;
  logic       none_q;

  logic       x1, x2, x3, x4;
  logic       cand_g, cand_h, cand_f;
  logic       cand_match;
  logic       slot_free;

  // Evaluate the example5 logic on the current candidate and compare it to
  // the latched request; a cleared care bit masks that output out.
  always_comb begin
    x1         = idx_q[0];
    x2         = idx_q[1];
    x3         = idx_q[2];
    x4         = idx_q[3];
    cand_g     = (x1 & x3) | (x2 & x4);
    cand_h     = (x1 | x3) & (x2 | x4);
    cand_f     = cand_g | cand_h;
    cand_match = (~care_q[2] | (cand_f == want_q[2])) &
                 (~care_q[1] | (cand_g == want_q[1])) &
                 (~care_q[0] | (cand_h == want_q[0]));
    // The output register can take a new vector if it is empty or being
    // consumed at this very edge.
    slot_free  = ~m_valid_q | m_ready;
  end

  // Control FSM, output register and match counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      want_q    <= '0;
      care_q    <= '0;
      m_valid_q <= 1'b0;
      m_x_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      count_q   <= '0;
      none_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults up front; a later assignment in the same
      // block overrides them, so done/none are single-cycle pulses and an
      // accepted vector is dropped unless a new match reloads the slot.
      done_q <= 1'b0;
      none_q <= 1'b0;
      if (m_valid_q && m_ready) begin
        m_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (start) begin
            want_q  <= {want_f, want_g, want_h};
            care_q  <= {care_f, care_g, care_h};
            count_q <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end

        SCAN: begin
          if (slot_free) begin
            if (cand_match) begin
              m_x_q     <= idx_q;
              m_valid_q <= 1'b1;
              count_q   <= count_q + 5'd1;
            end
            idx_q <= idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_q <= DRAIN;
            end
          end
        end

        DRAIN: begin
          if (slot_free) begin
            done_q  <= 1'b1;
            none_q  <= (count_q == 5'd0);
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign m_valid = m_valid_q;
  assign m_x     = m_x_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign count   = count_q;
  assign none    = none_q;

endmodule

// File: tb/tb_example5_preimage.sv
// Self-checking bench for example5_preimage: directed and random requests,
// compared against a reference list of preimages built from the boolean
// definition of example5, plus handshake, timing and reset behaviour.
module tb_example5_preimage;

  logic       clk;
  logic       reset;
  logic       start;
  logic       want_f, want_g, want_h;
  logic       care_f, care_g, care_h;
  logic       m_valid;
  logic       m_ready;
  logic [3:0] m_x;
  logic       busy;
  logic       done;
  logic [4:0] count;
  logic       none;

  int total;
  int bad;

  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  example5_preimage dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .want_f  (want_f),
    .want_g  (want_g),
    .want_h  (want_h),
    .care_f  (care_f),
    .care_g  (care_g),
    .care_h  (care_h),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_x     (m_x),
    .busy    (busy),
    .done    (done),
    .count   (count),
    .none    (none)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: every input vector whose example5 outputs satisfy the
  // masked request, in ascending order. want/care are {f, g, h}.
  function automatic void build_exp(input logic [2:0] want, input logic [2:0] care);
    exp_q.delete();
    for (int v = 0; v < 16; v++) begin
      bit a, b, c, d, g, h, f, ok;
      a  = (v % 2) == 1;          // x1
      b  = ((v / 2) % 2) == 1;    // x2
      c  = ((v / 4) % 2) == 1;    // x3
      d  = ((v / 8) % 2) == 1;    // x4
      g  = (a && c) || (b && d);
      h  = (a || c) && (b || d);
      f  = g || h;
      ok = (!care[2] || (f == want[2])) &&
           (!care[1] || (g == want[1])) &&
           (!care[0] || (h == want[0]));
      if (ok) exp_q.push_back(4'(v));
    end
  endfunction

  // One request, issued right after an active edge. mode: 0 = m_ready high,
  // 1 = m_ready toggles 1-0-1-0, 2 = random m_ready. poke pulses start with a
  // different request mid-scan, which must have no effect. Returns just after
  // the edge that raises done, so an immediate follow-up start lands in the
  // done cycle (earliest restart).
  task automatic run_request(input string tag, input logic [2:0] want,
                             input logic [2:0] care, input int mode, input bit poke);
    int         k;
    int         stalls;
    bit         finished;
    bit         stalled;
    bit         rdy;
    logic [3:0] held;

    build_exp(want, care);
    got_q.delete();
    {want_f, want_g, want_h} = want;
    {care_f, care_g, care_h} = care;
    start   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    k        = 0;
    stalls   = 0;
    finished = 1'b0;
    stalled  = 1'b0;
    held     = '0;

    while (!finished && k < 200) begin
      @(posedge clk);
      #1;
      k++;
      if (poke && k == 5) begin
        {want_f, want_g, want_h} = ~want;
        {care_f, care_g, care_h} = ~care;
        start = 1'b1;
      end
      if (poke && k == 6) start = 1'b0;

      if (stalled) begin
        check($sformatf("%s hold_valid k=%0d", tag, k), 32'(m_valid), 32'd1);
        check($sformatf("%s hold_x k=%0d", tag, k), 32'(m_x), 32'(held));
      end

      if (done) begin
        finished = 1'b1;
        check($sformatf("%s done_time", tag), 32'(k), 32'(17 + stalls));
        check($sformatf("%s busy_in_done", tag), 32'(busy), 32'd0);
        check($sformatf("%s count", tag), 32'(count), 32'(exp_q.size()));
        check($sformatf("%s none", tag), 32'(none), 32'(exp_q.size() == 0));
      end else begin
        check($sformatf("%s busy k=%0d", tag, k), 32'(busy), 32'd1);
        case (mode)
          0:       rdy = 1'b1;
          1:       rdy = (k % 2) == 1;
          default: rdy = $urandom_range(0, 3) != 0;
        endcase
        m_ready = rdy;
        stalled = 1'b0;
        if (m_valid) begin
          if (rdy) begin
            got_q.push_back(m_x);
          end else begin
            stalls++;
            stalled = 1'b1;
            held    = m_x;
          end
        end
      end
    end

    if (!finished) begin
      check($sformatf("%s timeout", tag), 32'd0, 32'd1);
    end
    check($sformatf("%s n_vectors", tag), 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s vec[%0d]", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    m_ready = 1'b1;
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b1;
    start   = 1'b0;
    m_ready = 1'b0;
    {want_f, want_g, want_h} = 3'b000;
    {care_f, care_g, care_h} = 3'b000;

    // Reset state.
    #12;
    check("rst m_valid", 32'(m_valid), 32'd0);
    check("rst m_x",     32'(m_x),     32'd0);
    check("rst busy",    32'(busy),    32'd0);
    check("rst done",    32'(done),    32'd0);
    check("rst count",   32'(count),   32'd0);
    check("rst none",    32'(none),    32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed requests; want/care are {f, g, h}. Back-to-back calls also
    // exercise the earliest restart.
    run_request("g1h1",      3'b011, 3'b011, 0, 1'b0);  // 7 11 13 14 15
    run_request("g1h0",      3'b010, 3'b011, 0, 1'b0);  // 5 10
    run_request("g0h1",      3'b001, 3'b011, 0, 1'b0);  // 3 6 9 12
    run_request("f0",        3'b000, 3'b100, 0, 1'b0);  // 0 1 2 4 8
    run_request("all_toggle",3'b000, 3'b000, 1, 1'b0);  // 0..15 with stalls
    run_request("inconsist", 3'b010, 3'b111, 0, 1'b0);  // no preimage

    // Reset in the middle of a scan with a vector pending.
    @(posedge clk);
    #1;
    {want_f, want_g, want_h} = 3'b000;
    {care_f, care_g, care_h} = 3'b000;
    start   = 1'b1;
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst m_valid", 32'(m_valid), 32'd1);
    check("pre_rst m_x",     32'(m_x),     32'd2);
    check("pre_rst count",   32'(count),   32'd3);
    m_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst m_valid", 32'(m_valid), 32'd0);
    check("mid_rst busy",    32'(busy),    32'd0);
    check("mid_rst count",   32'(count),   32'd0);
    check("mid_rst m_x",     32'(m_x),     32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Rescan from idx 0 after reset, with a start pulse during busy.
    run_request("after_rst_poke", 3'b000, 3'b000, 0, 1'b1);
    run_request("poke_g1h1",      3'b011, 3'b011, 2, 1'b1);

    // Random requests with random backpressure.
    for (int r = 0; r < 8; r++) begin
      logic [2:0] w;
      logic [2:0] c;
      w = 3'($urandom_range(0, 7));
      c = 3'($urandom_range(0, 7));
      run_request($sformatf("rnd%0d w=%0d c=%0d", r, w, c), w, c, 2, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
